// File: rtl/ps2_keycode_rx_if.sv
// Pin and PIO-side bundle for the PS/2 keycode receiver.
// The keyboard/host side drives the PS/2 pins; the receiver drives the decoded key state.
interface ps2_keycode_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode_export;
    logic       press_export;
    logic       ext_export;
    logic       code_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  keycode_export, press_export, ext_export, code_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output keycode_export, press_export, ext_export, code_valid, frame_err
    );
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix folding.
// Holds the last key event (code, make/break, extended) for software polling.
module ps2_keycode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    ps2_keycode_rx_if.slave ps2
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

    logic [1:0]            clk_sync_q;
    logic [1:0]            data_sync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  clk_filt_q;
    logic                  clk_filt_d;
    logic                  fall_evt_q;
    state_e                state_q;
    state_e                state_d;
    logic [2:0]            bit_cnt_q;
    logic [7:0]            shift_q;
    logic                  par_q;
    logic [TW-1:0]         tmo_q;
    logic                  byte_done_q;
    logic                  frame_err_q;
    logic                  code_valid_q;
    logic                  ext_pend_q;
    logic                  brk_pend_q;
    logic [7:0]            keycode_q;
    logic                  press_q;
    logic                  ext_q;

    logic data_s;
    logic tmo_hit;
    logic start_c, shift_c, par_c, done_c, err_c;

    assign data_s  = data_sync_q[1];
    // A falling edge in the same cycle as expiry keeps the frame alive.
    assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1)) && !fall_evt_q;

    // Level hysteresis: only a full run of equal samples moves the filtered clock.
    always_comb begin
        clk_filt_d = clk_filt_q;
        if (filt_q == '0) begin
            clk_filt_d = 1'b0;
        end else if (&filt_q) begin
            clk_filt_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= '1;
            clk_filt_q  <= 1'b1;
            fall_evt_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2.ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2.ps2_data};
            filt_q      <= {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
            clk_filt_q  <= clk_filt_d;
            fall_evt_q  <= clk_filt_q & ~clk_filt_d;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fall_evt_q) begin
            unique case (state_q)
                S_IDLE:   if (!data_s) state_d = S_DATA;
                S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        start_c = 1'b0;
        shift_c = 1'b0;
        par_c   = 1'b0;
        done_c  = 1'b0;
        err_c   = 1'b0;
        if (fall_evt_q) begin
            unique case (state_q)
                S_IDLE:   start_c = !data_s;
                S_DATA:   shift_c = 1'b1;
                S_PARITY: par_c   = 1'b1;
                S_STOP: begin
                    if (data_s && (^{shift_q, par_q})) done_c = 1'b1;
                    else                               err_c  = 1'b1;
                end
                default: ;
            endcase
        end else if (tmo_hit) begin
            err_c = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_done_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            code_valid_q <= 1'b0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            keycode_q    <= 8'h00;
            press_q      <= 1'b0;
            ext_q        <= 1'b0;
        end else begin
            if (start_c) begin
                bit_cnt_q <= 3'd0;
            end else if (shift_c) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (shift_c) shift_q <= {data_s, shift_q[7:1]};
            if (par_c)   par_q   <= data_s;

            if (fall_evt_q || state_q == S_IDLE) tmo_q <= '0;
            else                                 tmo_q <= tmo_q + 1'b1;

            byte_done_q  <= done_c;
            frame_err_q  <= err_c;
            code_valid_q <= 1'b0;

            // Shift register is stable after STOP, so it is read one cycle later here.
            if (err_c) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (byte_done_q) begin
                if (shift_q == 8'hE0) begin
                    ext_pend_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_pend_q <= 1'b1;
                end else begin
                    keycode_q    <= shift_q;
                    press_q      <= ~brk_pend_q;
                    ext_q        <= ext_pend_q;
                    code_valid_q <= 1'b1;
                    ext_pend_q   <= 1'b0;
                    brk_pend_q   <= 1'b0;
                end
            end
        end
    end

    assign ps2.keycode_export = keycode_q;
    assign ps2.press_export   = press_q;
    assign ps2.ext_export     = ext_q;
    assign ps2.code_valid     = code_valid_q;
    assign ps2.frame_err      = frame_err_q;
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: directed scenarios plus a random byte stream,
// checked against a key-event model working on whole bytes.
module tb_ps2_keycode_rx;
    localparam int FILT = 8;
    localparam int TMO  = 400;
    localparam int HALF = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ps2_keycode_rx_if ps2 ();

    ps2_keycode_rx #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .ps2           (ps2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;

    logic [7:0] m_key   = 8'h00;
    logic       m_press = 1'b0;
    logic       m_ext   = 1'b0;
    logic       m_extp  = 1'b0;
    logic       m_brkp  = 1'b0;

    always @(negedge clk) begin
        if (ps2.code_valid === 1'b1) cv_cnt++;
        if (ps2.frame_err === 1'b1) fe_cnt++;
        if (ps2.code_valid === 1'b1 && ps2.frame_err === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2.ps2_data = b;
        idle(HALF);
        ps2.ps2_clk = 1'b0;
        idle(HALF);
        ps2.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(~bad_stop);
        ps2.ps2_data = 1'b1;
        idle(HALF + 60);
    endtask

    task automatic model_byte(input logic [7:0] b, input logic good, output logic cv_e, output logic fe_e);
        cv_e = 1'b0;
        fe_e = 1'b0;
        if (!good) begin
            fe_e   = 1'b1;
            m_extp = 1'b0;
            m_brkp = 1'b0;
        end else if (b == 8'hE0) begin
            m_extp = 1'b1;
        end else if (b == 8'hF0) begin
            m_brkp = 1'b1;
        end else begin
            m_key   = b;
            m_press = !m_brkp;
            m_ext   = m_extp;
            cv_e    = 1'b1;
            m_extp  = 1'b0;
            m_brkp  = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/key"},   32'(ps2.keycode_export), 32'(m_key));
        check({tag, "/press"}, 32'(ps2.press_export),   32'(m_press));
        check({tag, "/ext"},   32'(ps2.ext_export),     32'(m_ext));
    endtask

    task automatic xact(input string tag, input logic [7:0] b, input logic bad_par, input logic bad_stop);
        int   cv0;
        int   fe0;
        logic cv_e;
        logic fe_e;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_frame(b, bad_par, bad_stop);
        model_byte(b, !(bad_par || bad_stop), cv_e, fe_e);
        check({tag, "/cv"}, cv_cnt - cv0, 32'(cv_e));
        check({tag, "/fe"}, fe_cnt - fe0, 32'(fe_e));
        check_outputs(tag);
        $display("xact %s byte=%02h bad_par=%0d bad_stop=%0d -> key=%02h press=%0d ext=%0d cv=%0d fe=%0d",
                 tag, b, bad_par, bad_stop, ps2.keycode_export, ps2.press_export, ps2.ext_export,
                 cv_cnt - cv0, fe_cnt - fe0);
    endtask

    task automatic model_reset();
        m_key   = 8'h00;
        m_press = 1'b0;
        m_ext   = 1'b0;
        m_extp  = 1'b0;
        m_brkp  = 1'b0;
    endtask

    initial begin
        int         cv0;
        int         fe0;
        int         r;
        logic [7:0] b;
        logic       bp;
        logic       bs;

        ps2.ps2_clk  = 1'b1;
        ps2.ps2_data = 1'b1;
        rst_n        = 1'b0;
        idle(5);
        check("reset/cv", 32'(ps2.code_valid), 32'd0);
        check("reset/fe", 32'(ps2.frame_err), 32'd0);
        check_outputs("reset");
        rst_n = 1'b1;
        idle(20);

        xact("make_1c", 8'h1C, 1'b0, 1'b0);
        xact("brk_f0", 8'hF0, 1'b0, 1'b0);
        xact("brk_1c", 8'h1C, 1'b0, 1'b0);
        xact("ext_e0", 8'hE0, 1'b0, 1'b0);
        xact("ext_75", 8'h75, 1'b0, 1'b0);
        xact("xbrk_e0", 8'hE0, 1'b0, 1'b0);
        xact("xbrk_f0", 8'hF0, 1'b0, 1'b0);
        xact("xbrk_75", 8'h75, 1'b0, 1'b0);
        xact("perr_1c", 8'h1C, 1'b1, 1'b0);
        xact("good_1c", 8'h1C, 1'b0, 1'b0);
        xact("serr_5a", 8'h5A, 1'b0, 1'b1);
        xact("typem_1c", 8'h1C, 1'b0, 1'b0);

        // Timeout after an E0 prefix: the prefix must be forgotten.
        xact("tmo_e0", 8'hE0, 1'b0, 1'b0);
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2.ps2_data = 1'b1;
        idle(TMO + 100);
        check("tmo/fe", fe_cnt - fe0, 32'd1);
        check("tmo/cv", cv_cnt - cv0, 32'd0);
        m_extp = 1'b0;
        m_brkp = 1'b0;
        $display("xact timeout partial frame -> fe=%0d cv=%0d", fe_cnt - fe0, cv_cnt - cv0);
        xact("post_tmo_1c", 8'h1C, 1'b0, 1'b0);

        // Short clock glitch with data low must not open a frame.
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        ps2.ps2_data = 1'b0;
        idle(5);
        ps2.ps2_clk = 1'b0;
        idle(4);
        ps2.ps2_clk = 1'b1;
        idle(5);
        ps2.ps2_data = 1'b1;
        idle(TMO + 50);
        check("glitch/fe", fe_cnt - fe0, 32'd0);
        check("glitch/cv", cv_cnt - cv0, 32'd0);
        $display("xact glitch 4-cycle clk low -> fe=%0d cv=%0d", fe_cnt - fe0, cv_cnt - cv0);
        xact("post_glitch_2b", 8'h2B, 1'b0, 1'b0);

        // Reset in the middle of a frame with an E0 prefix pending.
        xact("rst_e0", 8'hE0, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        idle(3);
        model_reset();
        check("midrst/cv", 32'(ps2.code_valid), 32'd0);
        check_outputs("midrst");
        ps2.ps2_data = 1'b1;
        idle(5);
        rst_n = 1'b1;
        idle(20);
        $display("xact mid-frame reset -> key=%02h press=%0d ext=%0d",
                 ps2.keycode_export, ps2.press_export, ps2.ext_export);
        xact("post_rst_1c", 8'h1C, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 25) begin
                b = 8'hE0;
            end else if (r < 45) begin
                b = 8'hF0;
            end else begin
                b = 8'($urandom);
                while (b == 8'hE0 || b == 8'hF0) b = 8'($urandom);
            end
            bp = ($urandom_range(0, 99) < 8);
            bs = !bp && ($urandom_range(0, 99) < 5);
            xact($sformatf("rnd%0d", i), b, bp, bs);
        end

        check("cv_fe_overlap", both_cnt, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
